// File: rtl/separador_digitos.sv
// Converts an unsigned binary value to decimal digits (double-dabble) and streams them
// MSD-first to the UART transmitter, one byte per tx_done handshake, then pulses done.
module separador_digitos #(
   parameter int         WIDTH     = 32,
   parameter int         NDIG      = 10,
   parameter bit         ASCII     = 1'b1,
   parameter bit         TERM_EN   = 1'b1,
   parameter logic [7:0] TERM_CHAR = 8'h0A
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] valor,
   input  logic             start,
   input  logic             tx_done,
   output logic [7:0]       dato,
   output logic             dato_valid,
   output logic             busy,
   output logic             done,
   output logic [2:0]       state_dbg
);

   localparam int BW = 4 * NDIG;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CONV, S_SKIP, S_SEND, S_WAIT, S_TERM, S_TWAIT, S_FIN
   } state_t;

   state_t           state, state_n;
   logic [BW-1:0]    bcd, bcd_n;
   logic [WIDTH-1:0] shift_r, shift_n;
   logic [CW-1:0]    bitcnt, bitcnt_n;
   logic [IW-1:0]    index, index_n;
   logic [7:0]       dato_n;
   logic             dato_valid_n;
   logic [3:0]       cur_digit;

   // Double-dabble correction: every nibble >= 5 gets +3 before the left shift.
   function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < NDIG; i++) begin
         if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [7:0] encode(input logic [3:0] d);
      return ASCII ? (8'h30 + {4'b0000, d}) : {4'b0000, d};
   endfunction

   assign cur_digit = bcd[{index, 2'b00} +: 4];
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FIN);
   assign state_dbg = state;

   // Handshake: dato_valid is a one-cycle load strobe with dato already stable; dato then
   // holds until the transmitter answers with a one-cycle tx_done, which is only honoured in
   // WAIT/TWAIT and never in the same cycle as the strobe it acknowledges.
   always_comb begin
      state_n      = state;
      bcd_n        = bcd;
      shift_n      = shift_r;
      bitcnt_n     = bitcnt;
      index_n      = index;
      dato_n       = dato;
      dato_valid_n = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               shift_n  = valor;
               bcd_n    = '0;
               bitcnt_n = '0;
               state_n  = S_CONV;
            end
         end
         S_CONV: begin
            {bcd_n, shift_n} = {dabble_adj(bcd), shift_r} << 1;
            bitcnt_n         = bitcnt + 1'b1;
            if (bitcnt == CW'(WIDTH - 1)) begin
               index_n = IW'(NDIG - 1);
               state_n = S_SKIP;
            end
         end
         S_SKIP: begin
            if (cur_digit != 4'd0 || index == '0) state_n = S_SEND;
            else                                  index_n = index - 1'b1;
         end
         S_SEND: begin
            dato_n       = encode(cur_digit);
            dato_valid_n = 1'b1;
            state_n      = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done && !dato_valid) begin
               if (index == '0) begin
                  state_n = TERM_EN ? S_TERM : S_FIN;
               end else begin
                  index_n = index - 1'b1;
                  state_n = S_SEND;
               end
            end
         end
         S_TERM: begin
            dato_n       = TERM_CHAR;
            dato_valid_n = 1'b1;
            state_n      = S_TWAIT;
         end
         S_TWAIT: begin
            if (tx_done && !dato_valid) state_n = S_FIN;
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         bcd        <= '0;
         shift_r    <= '0;
         bitcnt     <= '0;
         index      <= '0;
         dato       <= '0;
         dato_valid <= 1'b0;
      end else begin
         state      <= state_n;
         bcd        <= bcd_n;
         shift_r    <= shift_n;
         bitcnt     <= bitcnt_n;
         index      <= index_n;
         dato       <= dato_n;
         dato_valid <= dato_valid_n;
      end
   end

endmodule

// File: tb/tb_separador_digitos.sv
// Scoreboard bench for separador_digitos: default build (ASCII + terminator) and a raw,
// unterminated build driven by a small transmitter model with configurable ack delay.
module tb_separador_digitos;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] valor0, valor1;
   logic        start0, start1;
   logic        tx_done0, tx_done1, tx_done1_m, stray1;
   logic [7:0]  dato0, dato1;
   logic        dato_valid0, dato_valid1, busy0, busy1, done0, done1;
   logic [2:0]  st0, st1;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   int done_cnt0 = 0, done_cnt1 = 0;
   int tx_delay0 = 3, tx_delay1 = 100;

   assign tx_done1 = tx_done1_m | stray1;

   separador_digitos dut0 (
      .clk(clk), .reset(reset), .valor(valor0), .start(start0), .tx_done(tx_done0),
      .dato(dato0), .dato_valid(dato_valid0), .busy(busy0), .done(done0), .state_dbg(st0)
   );

   separador_digitos #(.ASCII(1'b0), .TERM_EN(1'b0)) dut1 (
      .clk(clk), .reset(reset), .valor(valor1), .start(start1), .tx_done(tx_done1),
      .dato(dato1), .dato_valid(dato_valid1), .busy(busy1), .done(done1), .state_dbg(st1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors: pop the expected byte whenever a DUT strobes dato_valid.
   always @(negedge clk) begin
      if (dato_valid0) begin
         if (exp_q0.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL byte0: got %02h, required no byte (t=%0t)", dato0, $time);
         end else chk("byte0", dato0, exp_q0.pop_front());
      end
      if (done0) begin
         chk("done0_bytes_left", exp_q0.size(), 0);
         done_cnt0++;
      end
   end

   always @(negedge clk) begin
      if (dato_valid1) begin
         if (exp_q1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL byte1: got %02h, required no byte (t=%0t)", dato1, $time);
         end else chk("byte1", dato1, exp_q1.pop_front());
      end
      if (done1) begin
         chk("done1_bytes_left", exp_q1.size(), 0);
         done_cnt1++;
      end
   end

   // Transmitter models: ack tx_delay cycles after each strobe, checking dato holds meanwhile.
   initial begin
      logic [7:0] held;
      tx_done0 = 1'b0;
      forever begin
         @(negedge clk);
         tx_done0 = 1'b0;
         if (dato_valid0) begin
            held = dato0;
            for (int i = 0; i < tx_delay0; i++) begin
               @(negedge clk);
               if (!busy0) break;
               chk("dato0_stable", dato0, held);
            end
            if (busy0) tx_done0 = 1'b1;
         end
      end
   end

   initial begin
      logic [7:0] held;
      tx_done1_m = 1'b0;
      forever begin
         @(negedge clk);
         tx_done1_m = 1'b0;
         if (dato_valid1) begin
            held = dato1;
            for (int i = 0; i < tx_delay1; i++) begin
               @(negedge clk);
               if (!busy1) break;
               chk("dato1_stable", dato1, held);
            end
            if (busy1) tx_done1_m = 1'b1;
         end
      end
   end

   task automatic start_dut0(input logic [31:0] v);
      @(negedge clk);
      valor0 = v;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic wait_done(input int which, input int budget, input string name);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (which == 0 ? done0 : done1) break;
      end
      if (i == budget) begin
         n_cmp++; n_err++;
         $display("FAIL %s: done not seen, required within %0d cycles", name, budget);
      end
   endtask

   task automatic push0(input logic [7:0] b);
      exp_q0.push_back(b);
   endtask

   initial begin
      int d0, lat, i;
      reset  = 1'b1;
      start0 = 1'b0; start1 = 1'b0; stray1 = 1'b0;
      valor0 = '0;   valor1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_dato0", dato0, 8'h00);
      chk("rst_valid0", dato_valid0, 1'b0);
      chk("rst_busy0", busy0, 1'b0);
      chk("rst_done0", done0, 1'b0);
      chk("rst_busy1", busy1, 1'b0);
      chk("rst_dato1", dato1, 8'h00);
      reset = 1'b0;
      @(negedge clk);

      // Value 0: a single "0" digit plus terminator.
      d0 = done_cnt0;
      push0(8'h30); push0(8'h0A);
      start_dut0(32'd0);
      wait_done(0, 300, "t1_done");
      repeat (3) @(negedge clk);
      chk("t1_done_count", done_cnt0, d0 + 1);

      // 1234 with first-byte latency: 1 + 32 + 6 + 1 cycles after the accepting edge.
      d0 = done_cnt0;
      push0(8'h31); push0(8'h32); push0(8'h33); push0(8'h34); push0(8'h0A);
      @(negedge clk);
      valor0 = 32'd1234;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      lat = 0;
      while (!dato_valid0 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("t2_first_byte_latency", lat, 40);
      wait_done(0, 300, "t2_done");
      repeat (3) @(negedge clk);
      chk("t2_done_count", done_cnt0, d0 + 1);

      // Full-scale value, no leading zeros.
      d0 = done_cnt0;
      push0(8'h34); push0(8'h32); push0(8'h39); push0(8'h34); push0(8'h39);
      push0(8'h36); push0(8'h37); push0(8'h32); push0(8'h39); push0(8'h35); push0(8'h0A);
      start_dut0(32'hFFFF_FFFF);
      wait_done(0, 500, "t3_done");
      repeat (3) @(negedge clk);
      chk("t3_done_count", done_cnt0, d0 + 1);

      // start re-pulsed mid-send must be ignored.
      d0 = done_cnt0;
      push0(8'h31); push0(8'h32); push0(8'h33); push0(8'h34); push0(8'h0A);
      start_dut0(32'd1234);
      for (i = 0; i < 100 && !dato_valid0; i++) @(negedge clk);
      chk("t4_first_byte_seen", dato_valid0, 1'b1);
      @(negedge clk);
      valor0 = 32'd7;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("t4_busy_held", busy0, 1'b1);
      wait_done(0, 300, "t4_done");
      repeat (3) @(negedge clk);
      chk("t4_done_count", done_cnt0, d0 + 1);

      // Reset while waiting for the ack of byte 32 aborts silently.
      push0(8'h31); push0(8'h32); push0(8'h33); push0(8'h34); push0(8'h0A);
      start_dut0(32'd1234);
      for (i = 0; i < 200 && !(dato_valid0 && dato0 == 8'h32); i++) @(negedge clk);
      chk("t5_byte32_seen", dato0, 8'h32);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t5_busy_after_rst", busy0, 1'b0);
      chk("t5_valid_after_rst", dato_valid0, 1'b0);
      chk("t5_done_after_rst", done0, 1'b0);
      exp_q0.delete();
      d0 = done_cnt0;
      repeat (60) @(negedge clk);
      chk("t5_no_done", done_cnt0, d0);
      push0(8'h35); push0(8'h36); push0(8'h0A);
      start_dut0(32'd56);
      wait_done(0, 300, "t5_done");
      repeat (3) @(negedge clk);
      chk("t5_done_count", done_cnt0, d0 + 1);

      // Raw digits, no terminator, slow transmitter, then a stray ack while idle.
      exp_q1.push_back(8'h09); exp_q1.push_back(8'h00); exp_q1.push_back(8'h05);
      @(negedge clk);
      valor1 = 32'd905;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done(1, 1000, "t6_done");
      repeat (3) @(negedge clk);
      chk("t6_done_count", done_cnt1, 1);
      stray1 = 1'b1;
      @(negedge clk);
      stray1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t6_stray_valid", dato_valid1, 1'b0);
      end
      chk("t6_stray_busy", busy1, 1'b0);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
